mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Byte-wide memory responder: the memory end of the multicycle datapath's memory interface.
- Accepts read/write requests on adr/writedata/memwrite/memread and returns read data on memdata with a configurable number of wait states.
- Signals each completion with a one-cycle memready pulse.
- Includes a sequential program-loader port used to fill memory before the core runs.

Parameters:
- ADDR_W, 8, address width; memory depth is 2**ADDR_W bytes.
- DATA_W, 8, data width.
- WAIT_STATES, 1, extra cycles between request accept and completion (0..15).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- adr  input  ADDR_W  request byte address.
- writedata  input  DATA_W  write data.
- memwrite  input  1  write request strobe.
- memread  input  1  read request strobe.
- memdata  output  DATA_W  read data, held until the next read completes.
- memready  output  1  one-cycle completion pulse.
- busy  output  1  high from accept until completion (inclusive).
- load_mode  input  1  loader owns memory while high.
- load_valid  input  1  load byte present.
- load_data  input  DATA_W  load byte.
- load_ready  output  1  loader may write this cycle.
- load_count  output  ADDR_W+1  bytes loaded since load_mode rose; saturates at 2**ADDR_W.

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE; wait counter = 0.
  - Outputs: memdata=0, memready=0, busy=0, load_ready=0.
  - Load pointer = 0, load_count = 0.
  - RAM contents are not cleared and are retained across reset.
- FSM states: IDLE, WAIT, RESP, LOAD.
- IDLE:
  - If load_mode=1, go to LOAD (load requests take priority over a simultaneous core request, which is dropped).
  - Otherwise, if memwrite or memread is high, accept: capture adr, writedata and op (memwrite wins if both are high).
  - After accept, go to WAIT if WAIT_STATES>0, else go to RESP.
- WAIT: count WAIT_STATES cycles, then go to RESP. Request inputs are ignored in this state.
- RESP:
  - Write: mem[adr_q] <= wdata_q.
  - Read: memdata <= mem[adr_q] (registered).
  - memready=1 for exactly this cycle; next state is IDLE.
  - The next request can be accepted in the cycle after RESP.
- Latency: accept at edge N gives memready high in the cycle after edge N+WAIT_STATES+1. Read data is valid on memdata in the same cycle memready is high.
- busy = (state==WAIT or state==RESP), plus the accept cycle output registered so that busy is high from the cycle after accept.
- Strobe levels: the core may hold strobes high past completion. A still-high strobe in IDLE after RESP is treated as a new request; the controller must drop strobes on memready.
- Back-to-back: write then read of the same address returns the new data (write commits in RESP before the next accept).
- LOAD state:
  - load_ready=1.
  - On each cycle with load_valid=1: mem[ptr] <= load_data; ptr increments, wrapping from 2**ADDR_W-1 to 0; load_count increments and saturates.
  - Core strobes are ignored; memready stays 0.
  - When load_mode falls, go to IDLE: ptr and load_count reset to 0 on the next rise of load_mode; load_count holds its value while in IDLE.
- load_mode rising mid-transaction (WAIT/RESP): the transaction completes normally; LOAD is entered from IDLE; load_ready stays 0 until then.
- Reset mid-transaction: the pending write is discarded, no memready is issued, RAM is unchanged.

Optional Feature:
- Macro: MEM_PARITY_EN.
- Defined:
  - Each byte stores an even-parity bit, computed on core writes and load writes.
  - Adds output parity_err (1 bit), asserted with memready when the stored parity mismatches the read byte; reset value 0.
  - Adds input par_inject: when high during a write, the stored parity bit is inverted.
- Undefined: no parity storage; the parity_err and par_inject ports are absent; all other behaviour is identical.

Test Plan:
- Reset, then load_mode=1 streaming bytes 0x20,0x02,0x00,0x05 -> mem[0..3] hold those bytes, load_count=4, memready never asserts.
- WAIT_STATES=1: read adr=0x03 accepted at cycle 10 -> memready high only in cycle 12, memdata=0x05; busy high in cycles 11-12.
- Write adr=0x80, data=0xA5, then read 0x80 -> write memready, then read memready with memdata=0xA5; mem[0x7F] and mem[0x81] unchanged.
- memread and memwrite both high with adr=0x10, data=0x3C -> treated as a write; memdata keeps its previous value; a later read of 0x10 returns 0x3C.
- Load 257 bytes (values 0x00..0xFF, then 0x77) -> mem[0]=0x77 (wrap), load_count saturates at 256; assert reset during a WAIT-state write to 0x40 -> no memready, mem[0x40] unchanged.
- With MEM_PARITY_EN: write 0x0F to 0x20 with par_inject=1, then read -> parity_err=1 with memready; without inject -> parity_err=0.

Source files
------------

// File: rtl/mem_responder.sv
// Byte-wide memory responder with programmable wait states and a sequential program loader.
// Optional per-byte even parity is built when MEM_PARITY_EN is defined.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] writedata,
  input  logic              memwrite,
  input  logic              memread,
  output logic [DATA_W-1:0] memdata,
  output logic              memready,
  output logic              busy,
  input  logic              load_mode,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
`ifdef MEM_PARITY_EN
  input  logic              par_inject,
  output logic              parity_err,
`endif
  output logic [ADDR_W:0]   load_count
);

  localparam int             DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [3:0]     WAIT_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_LOAD} state_t;

  state_t              state_q, state_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   memdata_q, memdata_d;
  logic                memready_q, busy_q, load_ready_q;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
`ifdef MEM_PARITY_EN
  logic                inj_q, inj_d;
  logic                perr_q, perr_d;
  logic                par_q [DEPTH];
`endif

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    adr_d     = adr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    memdata_d = memdata_q;
`ifdef MEM_PARITY_EN
    inj_d     = inj_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // Loader has priority; a coincident core request is dropped.
        if (load_mode) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
        end else if (memwrite || memread) begin
          adr_d   = adr;
          wdata_d = writedata;
          wr_d    = memwrite;
          wcnt_d  = '0;
`ifdef MEM_PARITY_EN
          inj_d   = par_inject;
`endif
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (wcnt_q == WAIT_LAST) state_d = S_RESP;
        else                     wcnt_d  = wcnt_q + 4'd1;
      end
      S_RESP: state_d = S_IDLE;
      S_LOAD: begin
        if (load_valid) begin
          ptr_d = ptr_q + 1'b1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
        if (!load_mode) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Read data is latched on entry to RESP so it is valid alongside memready.
    if (state_d == S_RESP && !wr_d) begin
      memdata_d = mem_q[adr_d];
`ifdef MEM_PARITY_EN
      perr_d    = (^mem_q[adr_d]) != par_q[adr_d];
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wcnt_q       <= '0;
      adr_q        <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      memdata_q    <= '0;
      memready_q   <= 1'b0;
      busy_q       <= 1'b0;
      load_ready_q <= 1'b0;
      ptr_q        <= '0;
      cnt_q        <= '0;
`ifdef MEM_PARITY_EN
      inj_q        <= 1'b0;
      perr_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      adr_q        <= adr_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
      memdata_q    <= memdata_d;
      memready_q   <= (state_d == S_RESP);
      busy_q       <= (state_d == S_WAIT) || (state_d == S_RESP);
      load_ready_q <= (state_d == S_LOAD);
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
`ifdef MEM_PARITY_EN
      inj_q        <= inj_d;
      perr_q       <= perr_d;
`endif
    end
  end

  // RAM has no reset; contents survive reset. A reset before RESP drops the write.
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && wr_q) begin
      mem_q[adr_q] <= wdata_q;
`ifdef MEM_PARITY_EN
      par_q[adr_q] <= (^wdata_q) ^ inj_q;
`endif
    end else if (state_q == S_LOAD && load_valid) begin
      mem_q[ptr_q] <= load_data;
`ifdef MEM_PARITY_EN
      par_q[ptr_q] <= (^load_data) ^ par_inject;
`endif
    end
  end

  assign memdata    = memdata_q;
  assign memready   = memready_q;
  assign busy       = busy_q;
  assign load_ready = load_ready_q;
  assign load_count = cnt_q;
`ifdef MEM_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: expected responses are queued at issue and
// popped by a monitor on every memready pulse.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] adr, writedata, load_data, memdata;
  logic       memwrite, memread, memready, busy;
  logic       load_mode, load_valid, load_ready;
  logic [8:0] load_count;
`ifdef MEM_PARITY_EN
  logic       par_inject, parity_err;
`endif

  typedef struct {
    logic [7:0] data;
    logic       perr;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] last_rd;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(1)) dut (
    .clk(clk), .reset(reset), .adr(adr), .writedata(writedata),
    .memwrite(memwrite), .memread(memread), .memdata(memdata),
    .memready(memready), .busy(busy), .load_mode(load_mode),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
`ifdef MEM_PARITY_EN
    .par_inject(par_inject), .parity_err(parity_err),
`endif
    .load_count(load_count)
  );

  // Scoreboard monitor: every completion must match the oldest expected response.
  always @(negedge clk) begin
    if (!reset && memready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_memready t=%0t memdata=%h", $time, memdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (memdata !== e.data) begin
          n_fail++;
          $display("FAIL resp_data t=%0t got=%h exp=%h", $time, memdata, e.data);
        end
`ifdef MEM_PARITY_EN
        n_checks++;
        if (parity_err !== e.perr) begin
          n_fail++;
          $display("FAIL parity_err t=%0t got=%b exp=%b", $time, parity_err, e.perr);
        end
`endif
      end
    end
  end

  task automatic issue(input bit we, input bit re, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] rd_exp, input bit perr_exp);
    exp_t e;
    bit   got;
    if (we) begin
      e.data = last_rd;
      e.perr = 1'b0;
    end else begin
      e.data  = rd_exp;
      e.perr  = perr_exp;
      last_rd = rd_exp;
    end
    sb.push_back(e);
    memwrite = we; memread = re; adr = a; writedata = d;
    @(negedge clk);
    memwrite = 1'b0; memread = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (memready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL req_timeout adr=%h got=no_memready exp=memready", a);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; memwrite = 0; memread = 0; adr = 0; writedata = 0;
    load_mode = 0; load_valid = 0; load_data = 0; last_rd = 8'h00;
`ifdef MEM_PARITY_EN
    par_inject = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({memdata, memready, busy, load_ready, load_count} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h/%b/%b/%b/%0d exp=0/0/0/0/0",
               memdata, memready, busy, load_ready, load_count);
    end
  endtask

  task automatic test_load();
    logic [7:0] vals[4] = '{8'h20, 8'h02, 8'h00, 8'h05};
    load_mode = 1'b1;
    @(negedge clk);
    n_checks++;
    if (load_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready_on got=%b exp=1", load_ready); end
    memread = 1'b1; adr = 8'h03;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = vals[i];
      if (i == 3) memread = 1'b0;
      @(negedge clk);
    end
    load_valid = 1'b0;
    n_checks++;
    if (load_count !== 9'd4) begin n_fail++; $display("FAIL load_count4 got=%0d exp=4", load_count); end
    load_mode = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (load_ready !== 1'b0 || load_count !== 9'd4) begin
      n_fail++;
      $display("FAIL load_exit got=%b/%0d exp=0/4", load_ready, load_count);
    end
    for (int i = 0; i < 3; i++) issue(0, 1, 8'(i), 8'h00, vals[i], 0);
  endtask

  task automatic test_read_latency();
    exp_t e;
    e.data = 8'h05; e.perr = 1'b0;
    sb.push_back(e); last_rd = 8'h05;
    memread = 1'b1; adr = 8'h03;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL lat_c10_busy got=%b exp=0", busy); end
    @(negedge clk);
    memread = 1'b0;
    n_checks++;
    if ({busy, memready} !== 2'b10) begin n_fail++; $display("FAIL lat_c11 got=%b%b exp=10", busy, memready); end
    @(negedge clk);
    n_checks++;
    if ({busy, memready} !== 2'b11 || memdata !== 8'h05) begin
      n_fail++; $display("FAIL lat_c12 got=%b%b/%h exp=11/05", busy, memready, memdata);
    end
    @(negedge clk);
    n_checks++;
    if ({busy, memready} !== 2'b00) begin n_fail++; $display("FAIL lat_c13 got=%b%b exp=00", busy, memready); end
  endtask

  task automatic test_back_to_back();
    issue(1, 0, 8'h7F, 8'h11, 8'h00, 0);
    issue(1, 0, 8'h81, 8'h22, 8'h00, 0);
    issue(1, 0, 8'h80, 8'hA5, 8'h00, 0);
    issue(0, 1, 8'h80, 8'h00, 8'hA5, 0);
    issue(0, 1, 8'h7F, 8'h00, 8'h11, 0);
    issue(0, 1, 8'h81, 8'h00, 8'h22, 0);
  endtask

  task automatic test_both_strobes();
    issue(1, 1, 8'h10, 8'h3C, 8'h00, 0);
    issue(0, 1, 8'h10, 8'h00, 8'h3C, 0);
  endtask

  task automatic test_load_wrap();
    load_mode = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 257; i++) begin
      load_valid = 1'b1;
      load_data  = (i == 256) ? 8'h77 : 8'(i);
      @(negedge clk);
    end
    load_valid = 1'b0;
    n_checks++;
    if (load_count !== 9'd256) begin n_fail++; $display("FAIL load_sat got=%0d exp=256", load_count); end
    load_mode = 1'b0;
    repeat (2) @(negedge clk);
    issue(0, 1, 8'h00, 8'h00, 8'h77, 0);
    issue(0, 1, 8'h01, 8'h00, 8'h01, 0);
    issue(0, 1, 8'hFF, 8'h00, 8'hFF, 0);
  endtask

  task automatic test_reset_mid();
    memwrite = 1'b1; adr = 8'h40; writedata = 8'hEE;
    @(negedge clk);
    memwrite = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got=%b exp=1", busy); end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, memready} !== 2'b00) begin n_fail++; $display("FAIL mid_async got=%b%b exp=00", busy, memready); end
    repeat (2) @(negedge clk);
    reset = 1'b0; last_rd = 8'h00;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (memready !== 1'b0 || memdata !== 8'h00 || load_count !== 9'd0) begin
        n_fail++; $display("FAIL post_reset got=%b/%h/%0d exp=0/00/0", memready, memdata, load_count);
      end
    end
    issue(0, 1, 8'h40, 8'h00, 8'h40, 0);
  endtask

`ifdef MEM_PARITY_EN
  task automatic test_parity();
    par_inject = 1'b1;
    issue(1, 0, 8'h20, 8'h0F, 8'h00, 0);
    par_inject = 1'b0;
    issue(0, 1, 8'h20, 8'h00, 8'h0F, 1);
    issue(1, 0, 8'h20, 8'h0F, 8'h00, 0);
    issue(0, 1, 8'h20, 8'h00, 8'h0F, 0);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_read_latency();
    test_back_to_back();
    test_both_strobes();
    test_load_wrap();
    test_reset_mid();
`ifdef MEM_PARITY_EN
    test_parity();
`endif
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
